// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with one op in flight and registered result/flags.
// Build option ALU_SEQ_MULDIV_EN adds iterative RV32M multiply/divide (CALC state); without it 1xxxx ops are illegal.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t          state, state_nxt;
    logic [XLEN-1:0] res_nxt;
    logic            zero_nxt, ill_nxt;

    function automatic logic [XLEN-1:0] base_alu(input logic [3:0] code,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        base_alu = '0;
        case (code)
            4'd0:  base_alu = b;
            4'd1:  base_alu = a + b;
            4'd2:  base_alu = a - b;
            4'd3:  base_alu = a & b;
            4'd4:  base_alu = a | b;
            4'd5:  base_alu = a ^ b;
            4'd6:  base_alu = a << sh;
            4'd7:  base_alu = a >> sh;
            4'd8:  base_alu = $unsigned($signed(a) >>> sh);
            4'd9:  base_alu = {{(XLEN-1){1'b0}}, (a < b)};
            4'd10: base_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd11: base_alu = (a > b) ? a : b;
            default: base_alu = '0;
        endcase
    endfunction

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    // hi:lo is the product (mul) or remainder:quotient (div); mc is the multiplicand/divisor magnitude
    logic [XLEN-1:0]   hi, lo, mc, hi_nxt, lo_nxt, mc_nxt;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [SHW-1:0]    cnt, cnt_nxt;
    logic [2:0]        mop, mop_nxt;
    logic              neg, neg_nxt;
    logic              sa, sb;
    logic [XLEN:0]     sum, shl, diff;
    logic [2*XLEN-1:0] prod;

    assign sa = num1[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
    assign sb = num2[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);

    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    assign shl     = {hi, lo[XLEN-1]};
    assign diff    = shl - {1'b0, mc};
    assign step_hi = mop[2] ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    assign step_lo = mop[2] ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
    assign prod    = neg ? -{step_hi, step_lo} : {step_hi, step_lo};
`endif

    always_comb begin
        state_nxt = state;
        res_nxt   = out_result;
        zero_nxt  = out_zero;
        ill_nxt   = out_illegal;
`ifdef ALU_SEQ_MULDIV_EN
        hi_nxt  = hi;
        lo_nxt  = lo;
        mc_nxt  = mc;
        cnt_nxt = cnt;
        mop_nxt = mop;
        neg_nxt = neg;
`endif
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    state_nxt = S_DONE;
                    zero_nxt  = (num1 == num2);
                    ill_nxt   = 1'b0;
                    res_nxt   = '0;
                    if (!op[4]) begin
                        if (op[3:2] == 2'b11) ill_nxt = 1'b1;
                        else                  res_nxt = base_alu(op[3:0], num1, num2);
                    end else begin
`ifdef ALU_SEQ_MULDIV_EN
                        mop_nxt = op[2:0];
                        cnt_nxt = SHW'(XLEN-1);
                        hi_nxt  = '0;
                        if (op[3]) begin
                            ill_nxt = 1'b1;
                        end else if (!op[2]) begin
                            lo_nxt    = neg_if(sb, num2);
                            mc_nxt    = neg_if(sa, num1);
                            neg_nxt   = sa ^ sb;
                            state_nxt = S_CALC;
                        end else if (num2 == '0) begin
                            res_nxt = op[1] ? num1 : '1;
                        end else if (!op[0] && num1 == SMIN && num2 == '1) begin
                            res_nxt = op[1] ? '0 : SMIN;
                        end else begin
                            lo_nxt    = neg_if(sa, num1);
                            mc_nxt    = neg_if(sb, num2);
                            neg_nxt   = op[1] ? sa : (sa ^ sb);
                            state_nxt = S_CALC;
                        end
`else
                        ill_nxt = 1'b1;
`endif
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_CALC: begin
                    hi_nxt  = step_hi;
                    lo_nxt  = step_lo;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == '0) begin
                        state_nxt = S_DONE;
                        case (mop)
                            3'b000:                 res_nxt = prod[XLEN-1:0];
                            3'b001, 3'b010, 3'b011: res_nxt = prod[2*XLEN-1:XLEN];
                            3'b100, 3'b101:         res_nxt = neg_if(neg, step_lo);
                            default:                res_nxt = neg_if(neg, step_hi);
                        endcase
                    end
                end
`endif
                S_DONE: if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            hi  <= '0;
            lo  <= '0;
            mc  <= '0;
            cnt <= '0;
            mop <= '0;
            neg <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            out_result  <= res_nxt;
            out_zero    <= zero_nxt;
            out_illegal <= ill_nxt;
`ifdef ALU_SEQ_MULDIV_EN
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            mc  <= mc_nxt;
            cnt <= cnt_nxt;
            mop <= mop_nxt;
            neg <= neg_nxt;
`endif
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (XLEN=32); M-op scenarios follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] num1, num2, out_result;
    logic            out_zero, out_illegal, busy;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [7:0]  lat;
    } vec_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] obs_res;
    logic        obs_zero, obs_ill;
    logic [7:0]  obs_lat;

    function automatic vec_t base_vec(input int i);
        case (i)
            0:  return '{5'b00001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 8'd1};
            1:  return '{5'b01000, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0, 8'd1};
            2:  return '{5'b01010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 8'd1};
            3:  return '{5'b01001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 8'd1};
            4:  return '{5'b00000, 32'h1234,      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd1};
            5:  return '{5'b00010, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0, 8'd1};
            6:  return '{5'b00011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 8'd1};
            7:  return '{5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 8'd1};
            8:  return '{5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 8'd1};
            9:  return '{5'b00110, 32'h1,         32'h3F,        32'h8000_0000, 1'b0, 1'b0, 8'd1};
            10: return '{5'b00111, 32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 1'b0, 8'd1};
            11: return '{5'b01011, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 8'd1};
            12: return '{5'b01010, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 8'd1};
            13: return '{5'b01100, 32'h5,         32'h5,         32'h0,         1'b1, 1'b1, 8'd1};
            14: return '{5'b01111, 32'h1,         32'h2,         32'h0,         1'b0, 1'b1, 8'd1};
            default: return '{5'b11000, 32'h9,    32'h3,         32'h0,         1'b0, 1'b1, 8'd1};
        endcase
    endfunction

`ifdef ALU_SEQ_MULDIV_EN
    function automatic vec_t m_vec(input int i);
        case (i)
            0:  return '{5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 8'd33};
            1:  return '{5'b10000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 8'd33};
            2:  return '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 8'd33};
            3:  return '{5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'd33};
            4:  return '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 8'd1};
            5:  return '{5'b10110, 32'h1234,      32'h0,         32'h1234,      1'b0, 1'b0, 8'd1};
            6:  return '{5'b10101, 32'h64,        32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 8'd1};
            7:  return '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 8'd1};
            8:  return '{5'b10100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 1'b0, 8'd33};
            9:  return '{5'b10110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 1'b0, 8'd33};
            10: return '{5'b10101, 32'hFFFF_FFFF, 32'h3,         32'h5555_5555, 1'b0, 1'b0, 8'd33};
            11: return '{5'b10111, 32'hFFFF_FFFF, 32'h7,         32'h3,         1'b0, 1'b0, 8'd33};
            12: return '{5'b10100, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 8'd1};
            13: return '{5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 8'd33};
            default: return '{5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0, 8'd33};
        endcase
    endfunction

    // Reference for random M ops using native 64-bit arithmetic
    function automatic logic [31:0] m_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        ia = a; ib = b;
        sa = ia; sb = ib; ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return ia / ib;
            3'd5: return a / b;
            3'd6: return ia % ib;
            default: return a % b;
        endcase
    endfunction
`endif

    task automatic start_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        @(negedge clk);
        op = o; num1 = a; num2 = b; in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        obs_lat = 8'd1;
        while (!out_valid && obs_lat < 8'd100) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_res = out_result; obs_zero = out_zero; obs_ill = out_illegal;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [36:0] got;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {in_ready, out_valid, busy, out_result, out_zero, out_illegal};
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: got %h, want %h", got, {1'b1, 35'h0, 1'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        got = {in_ready, out_valid, busy, out_result, out_zero, out_illegal};
        n_checks++;
        if (got !== {1'b1, 36'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got %h, want %h", got, {1'b1, 36'h0});
        end
    endtask

    task automatic test_table(input bit m_ops, input int n);
        vec_t v;
        exp_t e, o;
        for (int i = 0; i < n; i++) begin
`ifdef ALU_SEQ_MULDIV_EN
            v = m_ops ? m_vec(i) : base_vec(i);
`else
            v = base_vec(i);
            if (m_ops) v = '{5'b10000 | 5'(i % 8), 32'h3 + i, 32'h3, 32'h0, (i == 0), 1'b1, 8'd1};
`endif
            sb_q.push_back('{res: v.res, zero: v.zero, ill: v.ill, lat: v.lat});
            start_op(v.op, v.a, v.b);
            wait_out();
            e = sb_q.pop_front();
            o = {obs_res, obs_zero, obs_ill, obs_lat};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s[%0d] op=%b: got res=%h zero=%b ill=%b lat=%0d, want res=%h zero=%b ill=%b lat=%0d",
                         m_ops ? "mops" : "base", i, v.op, o.res, o.zero, o.ill, o.lat, e.res, e.zero, e.ill, e.lat);
            end
            consume();
        end
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic test_m_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        exp_t        e, o;
        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (b == 32'h0) b = 32'h1;
            if (b == 32'hFFFF_FFFF) b = 32'h5;
            sb_q.push_back('{res: m_model(f, a, b), zero: (a == b), ill: 1'b0, lat: 8'd33});
            start_op({2'b10, f}, a, b);
            wait_out();
            e = sb_q.pop_front();
            o = {obs_res, obs_zero, obs_ill, obs_lat};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mrand[%0d] f=%0d a=%h b=%h: got res=%h lat=%0d, want res=%h lat=%0d",
                         i, f, a, b, o.res, o.lat, e.res, e.lat);
            end
            consume();
        end
    endtask
`endif

    task automatic test_stall();
        exp_t        e, o;
        logic [34:0] got;
        sb_q.push_back('{res: 32'h7, zero: 1'b0, ill: 1'b0, lat: 8'd1});
        start_op(5'b00001, 32'h3, 32'h4);
        wait_out();
        e = sb_q.pop_front();
        o = {obs_res, obs_zero, obs_ill, obs_lat};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL stall_first: got res=%h lat=%0d, want res=%h lat=%0d", o.res, o.lat, e.res, e.lat);
        end
        op = 5'b00010; num1 = 32'h99; num2 = 32'h1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = {out_valid, in_ready, busy, out_result};
            n_checks++;
            if (got !== {1'b1, 1'b0, 1'b1, 32'h7}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h, want %h", i, got, {3'b101, 32'h7});
            end
        end
        in_valid = 1'b0;
        consume();
    endtask

    task automatic test_flush();
        logic [2:0] got;
        int         seen;
        exp_t       e, o;
        start_op(5'b00001, 32'h1, 32'h2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        got = {out_valid, busy, in_ready};
        n_checks++;
        if (got !== 3'b001) begin
            n_fail++;
            $display("FAIL flush_done: got %b, want 001", got);
        end
        op = 5'b00001; num1 = 32'h5; num2 = 32'h6; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        got = {out_valid, busy, in_ready};
        n_checks++;
        if (got !== 3'b001) begin
            n_fail++;
            $display("FAIL flush_vs_accept: got %b, want 001", got);
        end
`ifdef ALU_SEQ_MULDIV_EN
        start_op(5'b10000, 32'h1234, 32'h5678);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        got = {out_valid, busy, in_ready};
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (got !== 3'b001 || seen != 0) begin
            n_fail++;
            $display("FAIL flush_calc: got state %b valid_cycles %0d, want 001 and 0", got, seen);
        end
`endif
        sb_q.push_back('{res: 32'h7, zero: 1'b0, ill: 1'b0, lat: 8'd1});
        start_op(5'b00010, 32'hA, 32'h3);
        wait_out();
        e = sb_q.pop_front();
        o = {obs_res, obs_zero, obs_ill, obs_lat};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL flush_recover: got res=%h lat=%0d, want res=%h lat=%0d", o.res, o.lat, e.res, e.lat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        exp_t        e;
        logic [34:0] got, want;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 * (i + 1);
            b = (i == 2) ? a : i;
            op = 5'b00001; num1 = a; num2 = b; in_valid = 1'b1;
            sb_q.push_back('{res: a + b, zero: (a == b), ill: 1'b0, lat: 8'd1});
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b, want 1", i, in_ready);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            got  = {out_valid, in_ready, out_zero, out_result};
            want = {1'b1, 1'b0, e.zero, e.res};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %h, want %h", i, got, want);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [36:0] got;
        exp_t        e, o;
        sb_q.push_back('{res: 32'h2A, zero: 1'b1, ill: 1'b0, lat: 8'd1});
        start_op(5'b00001, 32'h15, 32'h15);
        wait_out();
        e = sb_q.pop_front();
        o = {obs_res, obs_zero, obs_ill, obs_lat};
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rmid_pre: got res=%h zero=%b, want res=%h zero=%b", o.res, o.zero, e.res, e.zero);
        end
`ifdef ALU_SEQ_MULDIV_EN
        consume();
        start_op(5'b10101, 32'd1000, 32'd7);
`endif
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        got = {in_ready, out_valid, busy, out_result, out_zero, out_illegal};
        n_checks++;
        if (got !== {1'b1, 36'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: got %h, want %h", got, {1'b1, 36'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 5'b0; num1 = '0; num2 = '0;
        test_reset();
        test_table(1'b0, 16);
`ifdef ALU_SEQ_MULDIV_EN
        test_table(1'b1, 15);
        test_m_random();
`else
        test_table(1'b1, 8);
`endif
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
